// File: rtl/serpent_core_sched_pkg.sv
// Shared definitions for the Serpent core scheduler: FSM states, key-bank selectors and
// the default core latency.
package serpent_core_sched_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait,
        StDone
    } state_e;

    localparam logic BANK_TW = 1'b1;
    localparam logic BANK_DT = 1'b0;

    localparam int unsigned CORE_LAT_DEFAULT = 36;

endpackage

// File: rtl/serpent_core_sched_if.sv
// Request/grant bundle between the scheduler FSM (master) and its two-input arbiter (slave).
interface serpent_core_sched_if;

    logic tw_req;
    logic dt_req;
    logic en;
    logic gnt_tw;
    logic gnt_dt;

    modport master (output tw_req, dt_req, en, input gnt_tw, gnt_dt);
    modport slave  (input tw_req, dt_req, en, output gnt_tw, gnt_dt);

endinterface

// File: rtl/serpent_sched_arb.sv
// Two-input grant logic for the tweak and data requesters. Fixed tweak priority by default;
// define SERPENT_SCHED_RR_EN for round-robin on simultaneous requests.
module serpent_sched_arb
    import serpent_core_sched_pkg::*;
(
    serpent_core_sched_if.slave arb
`ifdef SERPENT_SCHED_RR_EN
    ,
    input logic i_clk,
    input logic i_rstn
`endif
);

`ifdef SERPENT_SCHED_RR_EN
    // Set when tweak is next in line, i.e. data was the last requester served.
    logic tw_next_q;

    assign arb.gnt_tw = arb.en && arb.tw_req && (!arb.dt_req || tw_next_q);
    assign arb.gnt_dt = arb.en && arb.dt_req && (!arb.tw_req || !tw_next_q);

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            tw_next_q <= 1'b1;
        end else if (arb.gnt_tw || arb.gnt_dt) begin
            tw_next_q <= arb.gnt_dt;
        end
    end
`else
    assign arb.gnt_tw = arb.en && arb.tw_req;
    assign arb.gnt_dt = arb.en && arb.dt_req && !arb.tw_req;
`endif

endmodule

// File: rtl/serpent_core_sched.sv
// Schedules tweak and data blocks onto one shared Serpent core, one operation at a time.
// Optional SERPENT_SCHED_RR_EN selects round-robin arbitration instead of tweak priority.
module serpent_core_sched
    import serpent_core_sched_pkg::*;
#(
    parameter int unsigned CORE_LAT = CORE_LAT_DEFAULT
) (
    input  logic         i_clk,
    input  logic         i_rstn,
    input  logic         i_tw_req,
    input  logic [127:0] i_tw_data,
    output logic         o_tw_ack,
    output logic [127:0] o_tw_data,
    output logic         o_tw_valid,
    input  logic         i_dt_req,
    input  logic [127:0] i_dt_data,
    output logic         o_dt_ack,
    output logic [127:0] o_dt_data,
    output logic         o_dt_valid,
    input  logic         i_subkey_valid,
    output logic         o_core_en,
    output logic [127:0] o_core_data,
    input  logic [127:0] i_core_data,
    input  logic [5:0]   i_core_address,
    output logic [6:0]   o_key_address,
    output logic         o_busy
);

    localparam logic [5:0] LAST_CNT = 6'(CORE_LAT - 1);

    state_e     state_q;
    logic [5:0] cnt_q;
    logic       bank_q;

    serpent_core_sched_if arb_if ();

    assign arb_if.tw_req = i_tw_req;
    assign arb_if.dt_req = i_dt_req;
    assign arb_if.en     = (state_q == StIdle) && i_subkey_valid;

    serpent_sched_arb u_arb (
`ifdef SERPENT_SCHED_RR_EN
        .i_clk  (i_clk),
        .i_rstn (i_rstn),
`endif
        .arb    (arb_if)
    );

    assign o_busy        = (state_q != StIdle);
    assign o_key_address = o_busy ? {bank_q, i_core_address} : 7'd0;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bank_q      <= BANK_DT;
            o_tw_ack    <= 1'b0;
            o_dt_ack    <= 1'b0;
            o_core_en   <= 1'b0;
            o_tw_valid  <= 1'b0;
            o_dt_valid  <= 1'b0;
            o_core_data <= '0;
            o_tw_data   <= '0;
            o_dt_data   <= '0;
        end else begin
            o_tw_ack   <= 1'b0;
            o_dt_ack   <= 1'b0;
            o_core_en  <= 1'b0;
            o_tw_valid <= 1'b0;
            o_dt_valid <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (arb_if.gnt_tw || arb_if.gnt_dt) begin
                        bank_q      <= arb_if.gnt_tw ? BANK_TW : BANK_DT;
                        o_core_data <= arb_if.gnt_tw ? i_tw_data : i_dt_data;
                        o_tw_ack    <= arb_if.gnt_tw;
                        o_dt_ack    <= arb_if.gnt_dt;
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    o_core_en <= 1'b1;
                    cnt_q     <= '0;
                    state_q   <= StWait;
                end
                StWait: begin
                    if (cnt_q == LAST_CNT) begin
                        if (bank_q == BANK_TW) begin
                            o_tw_data <= i_core_data;
                        end else begin
                            o_dt_data <= i_core_data;
                        end
                        state_q <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 6'd1;
                    end
                end
                StDone: begin
                    // Strobe lands in the following IDLE cycle, alongside the next grant decision.
                    o_tw_valid <= (bank_q == BANK_TW);
                    o_dt_valid <= (bank_q == BANK_DT);
                    bank_q     <= BANK_DT;
                    state_q    <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_serpent_core_sched.sv
// Randomized self-checking bench for serpent_core_sched against a transaction-schedule model,
// plus directed scenarios with literal timing expectations.
module tb_serpent_core_sched;

    localparam int CORE_LAT = 36;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    serpent_core_sched_if bus ();

    logic [127:0] tw_data, dt_data, core_in;
    logic [5:0]   core_addr;
    logic         tw_ack, tw_valid, dt_ack, dt_valid, core_en, busy;
    logic [127:0] tw_out, dt_out, core_data;
    logic [6:0]   key_addr;

    assign bus.gnt_tw = tw_ack;
    assign bus.gnt_dt = dt_ack;

    serpent_core_sched #(.CORE_LAT(CORE_LAT)) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_tw_req       (bus.tw_req),
        .i_tw_data      (tw_data),
        .o_tw_ack       (tw_ack),
        .o_tw_data      (tw_out),
        .o_tw_valid     (tw_valid),
        .i_dt_req       (bus.dt_req),
        .i_dt_data      (dt_data),
        .o_dt_ack       (dt_ack),
        .o_dt_data      (dt_out),
        .o_dt_valid     (dt_valid),
        .i_subkey_valid (bus.en),
        .o_core_en      (core_en),
        .o_core_data    (core_data),
        .i_core_data    (core_in),
        .i_core_address (core_addr),
        .o_key_address  (key_addr),
        .o_busy         (busy)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc = 0;

    // Model: the most recent grant decision and the cycles its effects must appear on.
    bit           have;
    int           g;
    bit           gtw;
    logic [127:0] gblock, gval;
    int           free_from;
    bit           tw_next;
    logic [127:0] tw_res_e, dt_res_e, core_e;
    bit           ovr;
    logic [127:0] ovr_val;

    int ack_c, en_c, twv_c, n_ack, n_en, n_twv, kb, last_ack;
    bit ord_q[$];
    int dtv_q[$];

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic cmp(string name, logic [127:0] act, logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic reset_model();
        have = 0;
        g = 0;
        gtw = 0;
        free_from = 0;
        tw_next = 1;
        tw_res_e = '0;
        dt_res_e = '0;
        core_e = '0;
    endtask

    task automatic clear_obs();
        ack_c = -1; en_c = -1; twv_c = -1; last_ack = -1;
        n_ack = 0; n_en = 0; n_twv = 0; kb = 0;
        ord_q.delete();
        dtv_q.delete();
    endtask

    task automatic check();
        bit busy_e;
        busy_e = have && cyc >= g + 1 && cyc <= g + CORE_LAT + 2;
        if (have && cyc == g + 1) core_e = gblock;
        if (have && cyc == g + CORE_LAT + 2) begin
            if (gtw) tw_res_e = gval;
            else dt_res_e = gval;
        end
        cmp("tw_ack", 128'(tw_ack), 128'(have && cyc == g + 1 && gtw));
        cmp("dt_ack", 128'(dt_ack), 128'(have && cyc == g + 1 && !gtw));
        cmp("core_en", 128'(core_en), 128'(have && cyc == g + 2));
        cmp("busy", 128'(busy), 128'(busy_e));
        cmp("tw_valid", 128'(tw_valid), 128'(have && cyc == g + CORE_LAT + 3 && gtw));
        cmp("dt_valid", 128'(dt_valid), 128'(have && cyc == g + CORE_LAT + 3 && !gtw));
        cmp("core_data", core_data, core_e);
        cmp("tw_data", tw_out, tw_res_e);
        cmp("dt_data", dt_out, dt_res_e);
        if (busy_e) cmp("key_addr", 128'(key_addr), 128'({gtw, core_addr}));
        else cmp("key_bank", 128'(key_addr[6]), 128'(0));
        if (tw_ack || dt_ack) begin
            n_ack++;
            ord_q.push_back(tw_ack);
            if (ack_c < 0) ack_c = cyc;
            last_ack = cyc;
        end
        if (core_en) begin
            n_en++;
            if (en_c < 0) en_c = cyc;
        end
        if (tw_valid) begin
            n_twv++;
            if (twv_c < 0) twv_c = cyc;
        end
        if (dt_valid) dtv_q.push_back(cyc);
        if (busy && key_addr[6]) kb++;
    endtask

    task automatic decide();
        bit w;
        if (rstn && cyc >= free_from && bus.en && (bus.tw_req || bus.dt_req)) begin
`ifdef SERPENT_SCHED_RR_EN
            w = bus.tw_req && (!bus.dt_req || tw_next);
`else
            w = bus.tw_req;
`endif
            tw_next = !w;
            have = 1;
            g = cyc;
            gtw = w;
            gblock = w ? tw_data : dt_data;
            gval = ovr ? ovr_val : rnd128();
            free_from = cyc + CORE_LAT + 3;
        end
    endtask

    // Core model: the result is valid only on the one cycle the scheduler must sample it.
    task automatic core_drive();
        int t;
        t = g + 2;
        if (have && cyc >= t && cyc <= g + CORE_LAT + 2) begin
            core_addr = 6'(cyc - t);
            core_in = (cyc == t + CORE_LAT - 1) ? gval : rnd128();
        end else begin
            core_addr = 6'($urandom);
            core_in = rnd128();
        end
    endtask

    task automatic cycle_end();
        decide();
        core_drive();
        @(posedge clk);
        cyc++;
        @(negedge clk);
        check();
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        bus.tw_req = 1'b0;
        bus.dt_req = 1'b0;
        reset_model();
        cycle_end();
        cycle_end();
        rstn = 1'b1;
    endtask

    initial begin
        bus.tw_req = 1'b0;
        bus.dt_req = 1'b0;
        bus.en = 1'b0;
        tw_data = '0;
        dt_data = '0;
        core_in = '0;
        core_addr = '0;
        ovr = 0;
        ovr_val = '0;
        reset_model();
        clear_obs();
        #1;
        cmp("rst_busy", 128'(busy), 128'(0));
        cmp("rst_acks", 128'({tw_ack, dt_ack, core_en, tw_valid, dt_valid}), 128'(0));
        cmp("rst_core_data", core_data, 128'(0));
        cmp("rst_results", tw_out | dt_out, 128'(0));
        cmp("rst_key", 128'(key_addr), 128'(0));
        @(negedge clk);
        cycle_end();
        cycle_end();
        rstn = 1'b1;

        // Single tweak operation with a known core result.
        clear_obs();
        bus.en = 1'b1;
        tw_data = 128'h1;
        bus.tw_req = 1'b1;
        ovr = 1;
        ovr_val = 128'hA5;
        for (int i = 0; i < CORE_LAT + 6; i++) begin
            cycle_end();
            if (tw_ack) bus.tw_req = 1'b0;
        end
        ovr = 0;
        cmp("t1_acks", 128'(n_ack), 128'(1));
        cmp("t1_en_after_ack", 128'(en_c - ack_c), 128'(1));
        cmp("t1_valid_after_en", 128'(twv_c - en_c), 128'(CORE_LAT + 1));
        cmp("t1_result", tw_out, 128'hA5);
        cmp("t1_bank_cycles", 128'(kb), 128'(CORE_LAT + 2));

        // Grants blocked while subkeys invalid, then granted on the next cycle.
        clear_obs();
        bus.en = 1'b0;
        bus.dt_req = 1'b1;
        dt_data = rnd128();
        repeat (10) cycle_end();
        cmp("t2_no_ack", 128'(n_ack), 128'(0));
        cmp("t2_idle", 128'(busy), 128'(0));
        bus.en = 1'b1;
        cycle_end();
        cmp("t2_ack_next", 128'(dt_ack), 128'(1));
        bus.dt_req = 1'b0;
        repeat (CORE_LAT + 4) cycle_end();

        // Withdrawn request leaves no trace.
        bus.en = 1'b0;
        bus.dt_req = 1'b1;
        dt_data = rnd128();
        repeat (3) cycle_end();
        bus.dt_req = 1'b0;
        cycle_end();
        clear_obs();
        bus.en = 1'b1;
        repeat (5) cycle_end();
        cmp("t3_no_ack", 128'(n_ack), 128'(0));
        cmp("t3_no_core_en", 128'(n_en), 128'(0));

        // Both requesters held: arbitration order over four operations.
        clear_obs();
        bus.tw_req = 1'b1;
        bus.dt_req = 1'b1;
        tw_data = rnd128();
        dt_data = rnd128();
        for (int i = 0; i < 3 * (CORE_LAT + 3) + 3; i++) begin
            cycle_end();
            if (tw_ack) tw_data = rnd128();
            if (dt_ack) dt_data = rnd128();
        end
        cmp("t4_grant_count", 128'(ord_q.size() >= 4), 128'(1));
        if (ord_q.size() >= 4) begin
            for (int k = 0; k < 4; k++) begin
`ifdef SERPENT_SCHED_RR_EN
                cmp("t4_order", 128'(ord_q[k]), 128'(k % 2 == 0));
`else
                cmp("t4_order", 128'(ord_q[k]), 128'(1));
`endif
            end
        end
        bus.tw_req = 1'b0;
        for (int i = 0; i < 3 * (CORE_LAT + 3); i++) begin
            cycle_end();
            if (tw_ack) bus.tw_req = 1'b0;
            if (dt_ack) bus.dt_req = 1'b0;
        end

        // Back-to-back data blocks with subkey valid dropped mid-WAIT.
        clear_obs();
        bus.dt_req = 1'b1;
        dt_data = rnd128();
        for (int i = 0; i < 4 * (CORE_LAT + 3); i++) begin
            bus.en = !(last_ack >= 0 && cyc - last_ack >= 5 && cyc - last_ack <= 15);
            cycle_end();
            if (dt_ack) dt_data = rnd128();
        end
        bus.en = 1'b1;
        bus.dt_req = 1'b0;
        cmp("t5_valid_count", 128'(dtv_q.size() >= 3), 128'(1));
        if (dtv_q.size() >= 3) begin
            cmp("t5_gap0", 128'(dtv_q[1] - dtv_q[0]), 128'(CORE_LAT + 3));
            cmp("t5_gap1", 128'(dtv_q[2] - dtv_q[1]), 128'(CORE_LAT + 3));
        end
        repeat (CORE_LAT + 6) cycle_end();

        // Reset in WAIT with the counter at 10 discards the block.
        clear_obs();
        bus.dt_req = 1'b1;
        dt_data = rnd128();
        for (int i = 0; i < 5 && n_ack == 0; i++) cycle_end();
        bus.dt_req = 1'b0;
        cmp("t6_granted", 128'(n_ack), 128'(1));
        for (int i = 0; i < 20 && cyc < g + 12; i++) cycle_end();
        cmp("t6_busy_before", 128'(busy), 128'(1));
        #2;
        rstn = 1'b0;
        #1;
        cmp("t6_busy", 128'(busy), 128'(0));
        cmp("t6_strobes", 128'({tw_ack, dt_ack, core_en, tw_valid, dt_valid}), 128'(0));
        cmp("t6_core_data", core_data, 128'(0));
        cmp("t6_results", tw_out | dt_out, 128'(0));
        cmp("t6_key", 128'(key_addr), 128'(0));
        reset_model();
        cycle_end();
        cycle_end();
        @(negedge clk);
        rstn = 1'b1;
        clear_obs();
        repeat (CORE_LAT + 10) cycle_end();
        cmp("t6_no_valid", 128'(dtv_q.size()), 128'(0));

        // Randomized traffic with occasional resets.
        for (int i = 0; i < 4000; i++) begin
            if (i % 1000 == 777) do_reset();
            bus.en = ($urandom_range(0, 7) != 0);
            if (tw_ack) begin
                bus.tw_req = 1'($urandom_range(0, 1));
                tw_data = rnd128();
            end else if (bus.tw_req && $urandom_range(0, 15) == 0) begin
                bus.tw_req = 1'b0;
            end else if (!bus.tw_req && $urandom_range(0, 3) == 0) begin
                bus.tw_req = 1'b1;
                tw_data = rnd128();
            end
            if (dt_ack) begin
                bus.dt_req = 1'($urandom_range(0, 1));
                dt_data = rnd128();
            end else if (bus.dt_req && $urandom_range(0, 15) == 0) begin
                bus.dt_req = 1'b0;
            end else if (!bus.dt_req && $urandom_range(0, 3) == 0) begin
                bus.dt_req = 1'b1;
                dt_data = rnd128();
            end
            cycle_end();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/serpent_core_sched.md
SERPENT_CORE_SCHED -- requirements
Module: serpent_core_sched

Interface
REQ-001 SHALL have parameter CORE_LAT, default 36, meaning cycles from the core-start pulse to core result ready.
REQ-002 SHALL have ports i_clk in 1 clock; i_rstn in 1 reset, asynchronous, active-low.
REQ-003 SHALL have ports i_tw_req in 1 tweak request; i_tw_data in 128 tweak plaintext; o_tw_ack out 1 tweak accepted; o_tw_data out 128 tweak result; o_tw_valid out 1 tweak result strobe.
REQ-004 SHALL have ports i_dt_req in 1 data request; i_dt_data in 128 data block; o_dt_ack out 1 data accepted; o_dt_data out 128 data result; o_dt_valid out 1 data result strobe.
REQ-005 SHALL have ports i_subkey_valid in 1 both key banks expanded; o_core_en out 1 core start; o_core_data out 128 core input block; i_core_data in 128 core output; i_core_address in 6 core round index; o_key_address out 7 subkey memory address {bank, round}; o_busy out 1 operation in flight.

Function
REQ-006 SHALL implement FSM IDLE -> ISSUE -> WAIT -> DONE -> IDLE, one shared core, one operation at a time.
REQ-007 IDLE: with i_subkey_valid=1 and any request high, SHALL grant one requester, latch its data into o_core_data, pulse its ack for exactly one cycle, go to ISSUE.
REQ-008 Requester SHALL hold req and data stable until ack; dropping req before ack withdraws the request with no side effect.
REQ-009 Both requests high in IDLE SHALL be resolved per REQ-021 or REQ-022.
REQ-010 i_subkey_valid=0 SHALL block new grants; deassertion during ISSUE/WAIT/DONE SHALL NOT abort the operation.
REQ-011 ISSUE: o_core_en=1 for exactly one cycle; cycle counter cleared; go to WAIT.
REQ-012 WAIT: counter increments each cycle; when counter reaches CORE_LAT-1, sample i_core_data into the granted requester's result register, go to DONE.
REQ-013 DONE: pulse the granted requester's valid for exactly one cycle; go to IDLE; no grant in this cycle.
REQ-014 Result registers SHALL hold their value until overwritten by the next result for the same requester.
REQ-015 o_key_address SHALL equal {bank, i_core_address}, bank=1 for tweak, 0 for data, held from ISSUE through DONE; bank=0 in IDLE.
REQ-016 o_busy SHALL be 1 in ISSUE, WAIT, DONE; 0 in IDLE.
REQ-017 Requests arriving while busy SHALL wait; earliest grant is the IDLE cycle after DONE, giving back-to-back throughput of one block per CORE_LAT+3 cycles.
REQ-018 Counter SHALL be 6 bits and SHALL NOT wrap; CORE_LAT range is 2..63.

Reset
REQ-019 Asserting i_rstn low SHALL immediately force IDLE and zero every output, o_core_data, both result registers, and the counter; round-robin pointer points at data (tweak next).
REQ-020 Reset mid-operation SHALL discard the in-flight block: no valid pulse follows, and requesters re-request after reset release.

Configuration
REQ-021 With SERPENT_SCHED_RR_EN defined, simultaneous requests SHALL alternate round-robin; the pointer updates on each grant to the requester not just served.
REQ-022 Without SERPENT_SCHED_RR_EN, tweak SHALL always win simultaneous requests (fixed priority), and no pointer register exists.

Structure
REQ-023 Shared package SHALL hold state encodings (IDLE/ISSUE/WAIT/DONE), bank constants (BANK_TW=1, BANK_DT=0), and the default CORE_LAT.
REQ-024 One sub-module, serpent_sched_arb, SHALL hold the two-input grant logic including the optional round-robin pointer; the rest stays in the top.

Verification
REQ-025 Tweak req with i_tw_data=128'h1, core model returns 128'hA5 -> o_tw_ack in the grant cycle, o_core_en one cycle later, o_tw_valid with o_tw_data=128'hA5 exactly CORE_LAT+1 cycles after o_core_en, o_key_address[6]=1 throughout.
REQ-026 Both requests high, RR defined, 4 operations -> grant order tw, dt, tw, dt; RR undefined -> tw granted every time while held, dt never granted until tw drops.
REQ-027 i_subkey_valid=0 with i_dt_req=1 for 10 cycles -> no ack, o_busy=0; raise i_subkey_valid -> o_dt_ack next cycle.
REQ-028 Reset asserted in WAIT at counter=10 -> all outputs 0 within the same cycle; no o_dt_valid after release.
REQ-029 Data request dropped one cycle before a possible grant (subkey invalid), then subkey valid -> no ack, no core start.
REQ-030 Back-to-back data requests -> consecutive o_dt_valid pulses exactly CORE_LAT+3 cycles apart, i_subkey_valid toggled low mid-WAIT with no abort.
